// File: rtl/zigzag_rle.sv
// zigzag_rle: run-length encoder for zigzag-ordered 8x8 coefficient blocks.
// Emits (run, level) symbols: DC always passed through, nonzero AC with
// preceding zero-run, and an end-of-block marker on index 63.
// Optional feature macro: ZRLE_ZRL_EN (limits run to 15 and emits ZRL escapes).
module zigzag_rle #(
  parameter int unsigned COEF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              coef_valid,
  output logic              coef_ready,
  input  logic [COEF_W-1:0] coef_in,
  output logic              sym_valid,
  input  logic              sym_ready,
  output logic [5:0]        sym_run,
  output logic [COEF_W-1:0] sym_level,
  output logic              sym_dc,
  output logic              sym_eob,
  output logic              blk_done
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t      state;
  logic [5:0]  idx;
  logic [5:0]  run;

  logic        accept;
  logic        pop;
  logic        is_zero;
  logic        emit;
  logic        emit_dc;
  logic        emit_eob;
  logic [5:0]  run_out;
  logic [5:0]  run_nxt;

  assign sym_valid  = (state == FULL);
  assign coef_ready = !sym_valid || sym_ready;
  assign accept     = coef_valid && coef_ready;
  assign pop        = sym_valid && sym_ready;
  assign is_zero    = (coef_in == '0);

  // Classify the incoming coefficient by position and value.
  always_comb begin
    emit     = 1'b0;
    emit_dc  = 1'b0;
    emit_eob = 1'b0;
    run_out  = run;
    run_nxt  = run + 6'd1;
    if (idx == 6'd0) begin
      emit    = 1'b1;
      emit_dc = 1'b1;
      run_out = '0;
      run_nxt = '0;
    end else if (idx == 6'd63) begin
      // Trailing zeros are discarded: a zero here is a bare EOB.
      emit     = 1'b1;
      emit_eob = 1'b1;
      run_out  = is_zero ? 6'd0 : run;
      run_nxt  = '0;
    end else if (!is_zero) begin
      emit    = 1'b1;
      run_nxt = '0;
    end
`ifdef ZRLE_ZRL_EN
    else if (run == 6'd15) begin
      // Sixteenth consecutive zero: escape as ZRL {15, 0}.
      emit    = 1'b1;
      run_nxt = '0;
    end
`endif
  end

  // Output register / state, position and run counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      sym_run   <= '0;
      sym_level <= '0;
      sym_dc    <= 1'b0;
      sym_eob   <= 1'b0;
      blk_done  <= 1'b0;
      idx       <= '0;
      run       <= '0;
    end else begin
      blk_done <= accept && (idx == 6'd63);
      if (accept) begin
        idx <= idx + 6'd1;
        run <= run_nxt;
      end
      if (accept && emit) begin
        state     <= FULL;
        sym_run   <= run_out;
        sym_level <= coef_in;
        sym_dc    <= emit_dc;
        sym_eob   <= emit_eob;
      end else if (pop) begin
        state <= EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_zigzag_rle.sv
// tb_zigzag_rle: directed self-checking bench for zigzag_rle.
module tb_zigzag_rle;
  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          coef_valid;
  logic          coef_ready;
  logic [W-1:0]  coef_in;
  logic          sym_valid;
  logic          sym_ready;
  logic [5:0]    sym_run;
  logic [W-1:0]  sym_level;
  logic          sym_dc;
  logic          sym_eob;
  logic          blk_done;

  typedef struct packed {
    logic [5:0]   run;
    logic [W-1:0] level;
    logic         dc;
    logic         eob;
  } sym_t;

  sym_t         cur;
  sym_t         got[$];
  sym_t         exp_q[$];
  logic [W-1:0] blk[64];
  int           done_cnt  = 0;
  int           stall_err = 0;
  int           rule_err  = 0;
  int           tests     = 0;
  int           fails     = 0;
  logic         toggle    = 1'b0;
  logic         prev_stall;
  sym_t         prev_sym;

  zigzag_rle #(.COEF_W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready),
    .coef_in    (coef_in),
    .sym_valid  (sym_valid),
    .sym_ready  (sym_ready),
    .sym_run    (sym_run),
    .sym_level  (sym_level),
    .sym_dc     (sym_dc),
    .sym_eob    (sym_eob),
    .blk_done   (blk_done)
  );

  always #5 clk = ~clk;

  assign cur = {sym_run, sym_level, sym_dc, sym_eob};

  // Monitor on the falling edge: log popped symbols, blk_done pulses,
  // ready-rule and stall-stability violations.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (coef_ready !== (!sym_valid || sym_ready)) rule_err++;
      if (prev_stall && (sym_valid !== 1'b1 || cur !== prev_sym)) stall_err++;
      if (sym_valid && sym_ready) got.push_back(cur);
      if (blk_done === 1'b1) done_cnt++;
      prev_stall = sym_valid && !sym_ready;
      prev_sym   = cur;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic sym_t mk(input logic [5:0] r, input logic [W-1:0] l,
                              input logic d, input logic e);
    mk = {r, l, d, e};
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
    if (toggle) sym_ready = ~sym_ready;
  endtask

  task automatic push_coef(input logic [W-1:0] c);
    int   n  = 0;
    logic ok = 1'b0;
    coef_valid = 1'b1;
    coef_in    = c;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = coef_ready;
      cycle();
      n++;
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL push_timeout: coef_ready=%b after %0d cycles, required 1", coef_ready, n);
    end
  endtask

  task automatic clear_blk();
    for (int i = 0; i < 64; i++) blk[i] = '0;
  endtask

  task automatic send_block();
    for (int i = 0; i < 64; i++) push_coef(blk[i]);
  endtask

  task automatic drain();
    coef_valid = 1'b0;
    repeat (6) cycle();
    toggle    = 1'b0;
    sym_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; coef_valid = 1'b0; coef_in = '0; sym_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (sym_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b want 0", sym_valid); end
    tests++; if (sym_run !== 6'd0) begin fails++; $display("FAIL rst_run: got %0d want 0", sym_run); end
    tests++; if (sym_level !== '0) begin fails++; $display("FAIL rst_level: got %0d want 0", sym_level); end
    tests++; if (sym_dc !== 1'b0 || sym_eob !== 1'b0) begin fails++; $display("FAIL rst_flags: got dc=%b eob=%b want 0 0", sym_dc, sym_eob); end
    tests++; if (blk_done !== 1'b0) begin fails++; $display("FAIL rst_done: got %b want 0", blk_done); end
    rst = 1'b0;
    tests++; if (coef_ready !== 1'b1) begin fails++; $display("FAIL rst_ready: got %b want 1", coef_ready); end
  endtask

  task automatic test_dc_only();
    int base = got.size();
    int d0   = done_cnt;
    sym_ready  = 1'b1;
    coef_valid = 1'b1;
    coef_in    = 32'd5;
    @(negedge clk);
    cycle();
    tests++;
    if (sym_valid !== 1'b1 || sym_level !== 32'd5 || sym_dc !== 1'b1) begin
      fails++; $display("FAIL dc_latency: got valid=%b level=%0d dc=%b want 1 5 1", sym_valid, sym_level, sym_dc);
    end
    for (int i = 1; i < 64; i++) push_coef('0);
    tests++;
    if (blk_done !== 1'b1 || sym_valid !== 1'b1 || sym_eob !== 1'b1) begin
      fails++; $display("FAIL dc_done_timing: got done=%b valid=%b eob=%b want 1 1 1", blk_done, sym_valid, sym_eob);
    end
    drain();
    exp_q.delete();
    exp_q.push_back(mk(6'd0, 32'd5, 1'b1, 1'b0));
    exp_q.push_back(mk(6'd0, 32'd0, 1'b0, 1'b1));
    tests++; if (got.size() - base != exp_q.size()) begin fails++; $display("FAIL dc_count: got %0d want %0d", got.size() - base, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && base + i < got.size(); i++) begin
      tests++;
      if (got[base+i] !== exp_q[i]) begin
        fails++;
        $display("FAIL dc_sym%0d: got run=%0d level=%0d dc=%b eob=%b want run=%0d level=%0d dc=%b eob=%b", i,
          got[base+i].run, $signed(got[base+i].level), got[base+i].dc, got[base+i].eob,
          exp_q[i].run, $signed(exp_q[i].level), exp_q[i].dc, exp_q[i].eob);
      end
    end
    tests++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL dc_done_count: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_mixed();
    int base = got.size();
    clear_blk();
    blk[1] = -32'sd3; blk[4] = 32'd7; blk[63] = 32'd2;
    sym_ready = 1'b1;
    send_block();
    drain();
    exp_q.delete();
    exp_q.push_back(mk(6'd0,  32'd0,   1'b1, 1'b0));
    exp_q.push_back(mk(6'd0,  -32'sd3, 1'b0, 1'b0));
    exp_q.push_back(mk(6'd2,  32'd7,   1'b0, 1'b0));
    exp_q.push_back(mk(6'd58, 32'd2,   1'b0, 1'b1));
    tests++; if (got.size() - base != exp_q.size()) begin fails++; $display("FAIL mixed_count: got %0d want %0d", got.size() - base, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && base + i < got.size(); i++) begin
      tests++;
      if (got[base+i] !== exp_q[i]) begin
        fails++;
        $display("FAIL mixed_sym%0d: got run=%0d level=%0d dc=%b eob=%b want run=%0d level=%0d dc=%b eob=%b", i,
          got[base+i].run, $signed(got[base+i].level), got[base+i].dc, got[base+i].eob,
          exp_q[i].run, $signed(exp_q[i].level), exp_q[i].dc, exp_q[i].eob);
      end
    end
  endtask

  task automatic test_last_only();
    int base = got.size();
    clear_blk();
    blk[63] = 32'd1;
    sym_ready = 1'b1;
    send_block();
    drain();
    exp_q.delete();
    exp_q.push_back(mk(6'd0,  32'd0, 1'b1, 1'b0));
    exp_q.push_back(mk(6'd62, 32'd1, 1'b0, 1'b1));
    tests++; if (got.size() - base != exp_q.size()) begin fails++; $display("FAIL last_count: got %0d want %0d", got.size() - base, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && base + i < got.size(); i++) begin
      tests++;
      if (got[base+i] !== exp_q[i]) begin
        fails++;
        $display("FAIL last_sym%0d: got run=%0d level=%0d dc=%b eob=%b want run=%0d level=%0d dc=%b eob=%b", i,
          got[base+i].run, $signed(got[base+i].level), got[base+i].dc, got[base+i].eob,
          exp_q[i].run, $signed(exp_q[i].level), exp_q[i].dc, exp_q[i].eob);
      end
    end
  endtask

  task automatic test_zrl();
    int base = got.size();
    clear_blk();
    blk[0] = 32'd1; blk[21] = 32'd9;
    sym_ready = 1'b1;
    send_block();
    drain();
    exp_q.delete();
    exp_q.push_back(mk(6'd0,  32'd1, 1'b1, 1'b0));
    exp_q.push_back(mk(6'd15, 32'd0, 1'b0, 1'b0));
    exp_q.push_back(mk(6'd4,  32'd9, 1'b0, 1'b0));
    exp_q.push_back(mk(6'd15, 32'd0, 1'b0, 1'b0));
    exp_q.push_back(mk(6'd15, 32'd0, 1'b0, 1'b0));
    exp_q.push_back(mk(6'd0,  32'd0, 1'b0, 1'b1));
    tests++; if (got.size() - base != exp_q.size()) begin fails++; $display("FAIL zrl_count: got %0d want %0d", got.size() - base, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && base + i < got.size(); i++) begin
      tests++;
      if (got[base+i] !== exp_q[i]) begin
        fails++;
        $display("FAIL zrl_sym%0d: got run=%0d level=%0d dc=%b eob=%b want run=%0d level=%0d dc=%b eob=%b", i,
          got[base+i].run, $signed(got[base+i].level), got[base+i].dc, got[base+i].eob,
          exp_q[i].run, $signed(exp_q[i].level), exp_q[i].dc, exp_q[i].eob);
      end
    end
  endtask

  task automatic test_back_to_back();
    int base = got.size();
    int d0   = done_cnt;
    int s0   = stall_err;
    int r0   = rule_err;
    sym_ready = 1'b1;
    toggle    = 1'b1;
    clear_blk();
    blk[0] = 32'd3; blk[10] = -32'sd1;
    send_block();
    clear_blk();
    blk[0] = -32'sd7; blk[1] = 32'd1; blk[2] = 32'd2; blk[62] = 32'd4; blk[63] = 32'd5;
    send_block();
    drain();
    exp_q.delete();
    exp_q.push_back(mk(6'd0,  32'd3,   1'b1, 1'b0));
    exp_q.push_back(mk(6'd9,  -32'sd1, 1'b0, 1'b0));
    exp_q.push_back(mk(6'd0,  32'd0,   1'b0, 1'b1));
    exp_q.push_back(mk(6'd0,  -32'sd7, 1'b1, 1'b0));
    exp_q.push_back(mk(6'd0,  32'd1,   1'b0, 1'b0));
    exp_q.push_back(mk(6'd0,  32'd2,   1'b0, 1'b0));
    exp_q.push_back(mk(6'd59, 32'd4,   1'b0, 1'b0));
    exp_q.push_back(mk(6'd0,  32'd5,   1'b0, 1'b1));
    tests++; if (got.size() - base != exp_q.size()) begin fails++; $display("FAIL b2b_count: got %0d want %0d", got.size() - base, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && base + i < got.size(); i++) begin
      tests++;
      if (got[base+i] !== exp_q[i]) begin
        fails++;
        $display("FAIL b2b_sym%0d: got run=%0d level=%0d dc=%b eob=%b want run=%0d level=%0d dc=%b eob=%b", i,
          got[base+i].run, $signed(got[base+i].level), got[base+i].dc, got[base+i].eob,
          exp_q[i].run, $signed(exp_q[i].level), exp_q[i].dc, exp_q[i].eob);
      end
    end
    tests++; if (done_cnt - d0 != 2) begin fails++; $display("FAIL b2b_done_count: got %0d want 2", done_cnt - d0); end
    tests++; if (stall_err != s0) begin fails++; $display("FAIL b2b_stall_stable: got %0d violations want 0", stall_err - s0); end
    tests++; if (rule_err != r0) begin fails++; $display("FAIL b2b_ready_rule: got %0d violations want 0", rule_err - r0); end
  endtask

  task automatic test_mid_reset();
    int base;
    int d0;
    sym_ready = 1'b1;
    for (int i = 0; i < 30; i++) push_coef(i == 0 ? 32'd4 : (i == 29 ? 32'd6 : 32'd0));
    coef_valid = 1'b0;
    sym_ready  = 1'b0;
    tests++;
    if (sym_valid !== 1'b1 || sym_level !== 32'd6) begin
      fails++; $display("FAIL mrst_pending: got valid=%b level=%0d want 1 6", sym_valid, sym_level);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    tests++; if (sym_valid !== 1'b0) begin fails++; $display("FAIL mrst_valid: got %b want 0", sym_valid); end
    rst       = 1'b0;
    sym_ready = 1'b1;
    base = got.size();
    d0   = done_cnt;
    clear_blk();
    blk[0] = 32'd9; blk[3] = 32'd1;
    send_block();
    drain();
    exp_q.delete();
    exp_q.push_back(mk(6'd0, 32'd9, 1'b1, 1'b0));
    exp_q.push_back(mk(6'd2, 32'd1, 1'b0, 1'b0));
    exp_q.push_back(mk(6'd0, 32'd0, 1'b0, 1'b1));
    tests++; if (got.size() - base != exp_q.size()) begin fails++; $display("FAIL mrst_count: got %0d want %0d", got.size() - base, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && base + i < got.size(); i++) begin
      tests++;
      if (got[base+i] !== exp_q[i]) begin
        fails++;
        $display("FAIL mrst_sym%0d: got run=%0d level=%0d dc=%b eob=%b want run=%0d level=%0d dc=%b eob=%b", i,
          got[base+i].run, $signed(got[base+i].level), got[base+i].dc, got[base+i].eob,
          exp_q[i].run, $signed(exp_q[i].level), exp_q[i].dc, exp_q[i].eob);
      end
    end
    tests++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL mrst_done_count: got %0d want 1", done_cnt - d0); end
  endtask

  initial begin
    test_reset();
    test_dc_only();
`ifdef ZRLE_ZRL_EN
    test_zrl();
`else
    test_mixed();
    test_last_only();
`endif
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
